priority_resolver_n: RTL and testbench

PRIORITY_RESOLVER_N -- requirements
Module: priority_resolver_n

---
 rtl/priority_resolver_n.sv | 109 ++++++++++
 tb/tb_priority_resolver_n.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_n.sv
// priority_resolver_n: interrupt priority resolver with rotation, masking and two-pulse acknowledge
module priority_resolver_n #(
  parameter int          NUM_IRQ  = 8,
  parameter logic [7:0]  VEC_BASE = 8'h20,
  localparam int         IDXW     = $clog2(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] IR,
  input  logic [NUM_IRQ-1:0] IM,
  input  logic               LTIM,
  input  logic [1:0]         ROT_MODE,
  input  logic [IDXW-1:0]    ROT_LEVEL,
  input  logic               INTA_N,
  input  logic               EOI,
  input  logic               SEOI,
  input  logic [IDXW-1:0]    EOI_LEVEL,
  output logic               INT,
  output logic [NUM_IRQ-1:0] IRR,
  output logic [NUM_IRQ-1:0] ISR,
  output logic [7:0]         VECTOR,
  output logic               VEC_VALID
);
  typedef enum logic {IDLE, WAIT2} state_t;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_IRQ - 1);
  state_t               r_state, w_state_next;
  logic                 r_inta_prev, r_int, r_vv;
  logic [NUM_IRQ-1:0]   r_ir_prev, r_irr, r_isr;
  logic [IDXW-1:0]      r_low, r_k, w_low;
  logic [7:0]           r_vec;
  logic                 w_pulse, w_first, w_second, w_ack, w_int_next;
  logic [IDXW:0]        w_win, w_top;
  logic [NUM_IRQ-1:0]   w_sel, w_eoi_clr, w_seoi_clr, w_irr_next, w_isr_next;

  // highest-priority set bit of v, scanning circularly from low+1; msb flags "found"
  function automatic logic [IDXW:0] pick(input logic [NUM_IRQ-1:0] v, input logic [IDXW-1:0] low);
    logic [IDXW:0] r;
    int p;
    r = '0;
    for (int j = NUM_IRQ - 1; j >= 0; j--) begin
      p = int'(low) + 1 + j;
      if (p >= NUM_IRQ) p -= NUM_IRQ;
      if (v[p[IDXW-1:0]]) r = {1'b1, p[IDXW-1:0]};
    end
    return r;
  endfunction

  // circular distance from the highest-priority level; 0 is most urgent
  function automatic logic [IDXW-1:0] rank(input logic [IDXW-1:0] idx, input logic [IDXW-1:0] low);
    int p;
    p = int'(idx) - int'(low) - 1;
    if (p < 0) p += NUM_IRQ;
    return p[IDXW-1:0];
  endfunction

  // handshake state register
  always_ff @(posedge CLK)
    if (RST) r_state <= IDLE;
    else r_state <= w_state_next;

  // acknowledge decode, next state, priority resolution and register next values
  always_comb begin
    w_pulse      = r_inta_prev & ~INTA_N;
    w_first      = w_pulse && r_state == IDLE;
    w_second     = w_pulse && r_state == WAIT2;
    w_state_next = w_first ? WAIT2 : w_second ? IDLE : r_state;
    w_low        = ROT_MODE[1] ? r_low : LAST;
    w_win        = pick(r_irr & ~IM, w_low);
    w_top        = pick(r_isr, w_low);
    w_ack        = w_first & w_win[IDXW];
    w_sel        = w_ack ? NUM_IRQ'(1) << w_win[IDXW-1:0] : '0;
    w_eoi_clr    = (EOI & w_top[IDXW]) ? NUM_IRQ'(1) << w_top[IDXW-1:0] : '0;
    w_seoi_clr   = SEOI ? NUM_IRQ'(1) << EOI_LEVEL : '0;
    w_irr_next   = LTIM ? (IR & ~w_sel) : ((r_irr & ~w_sel) | (IR & ~r_ir_prev));
    w_isr_next   = (r_isr & ~w_eoi_clr & ~w_seoi_clr) | w_sel;
    w_int_next   = w_state_next == IDLE && w_win[IDXW] &&
                   (!w_top[IDXW] || rank(w_win[IDXW-1:0], w_low) < rank(w_top[IDXW-1:0], w_low));
  end

  // request/service registers, rotation pointer, latched winner and vector output
  always_ff @(posedge CLK)
    if (RST) begin
      r_inta_prev <= 1'b1;
      r_ir_prev   <= '0;
      r_irr       <= '0;
      r_isr       <= '0;
      r_int       <= 1'b0;
      r_vv        <= 1'b0;
      r_vec       <= 8'h00;
      r_low       <= LAST;
      r_k         <= LAST;
    end else begin
      r_inta_prev <= INTA_N;
      r_ir_prev   <= IR;
      r_irr       <= w_irr_next;
      r_isr       <= w_isr_next;
      r_int       <= w_int_next;
      r_vv        <= w_second;
      if (w_first) r_k <= w_win[IDXW] ? w_win[IDXW-1:0] : LAST;
      if (w_second) r_vec <= {VEC_BASE[7:IDXW], r_k};
      r_low <= ROT_MODE == 2'b11 ? ROT_LEVEL : ROT_MODE == 2'b10 ? (w_ack ? w_win[IDXW-1:0] : r_low) : LAST;
    end

  assign INT       = r_int;
  assign IRR       = r_irr;
  assign ISR       = r_isr;
  assign VECTOR    = r_vec;
  assign VEC_VALID = r_vv;
endmodule

// File: tb/tb_priority_resolver_n.sv
// tb_priority_resolver_n: directed vectors plus randomized run against a behavioural model
module tb_priority_resolver_n;
  localparam int N = 8;
  logic       CLK = 1'b0, RST, LTIM, INTA_N, EOI, SEOI, INT, VEC_VALID;
  logic [7:0] IR, IM, IRR, ISR, VECTOR;
  logic [1:0] ROT_MODE;
  logic [2:0] ROT_LEVEL, EOI_LEVEL;
  int         n_checks = 0, n_errors = 0;
  bit         chk_model = 0;
  logic [7:0] m_irr, m_isr, m_ir_prev, m_vec;
  logic       m_inta_prev, m_vv, m_int;
  int         m_low, m_k, m_state;

  priority_resolver_n #(.NUM_IRQ(8), .VEC_BASE(8'h20)) dut (
    .CLK(CLK), .RST(RST), .IR(IR), .IM(IM), .LTIM(LTIM), .ROT_MODE(ROT_MODE),
    .ROT_LEVEL(ROT_LEVEL), .INTA_N(INTA_N), .EOI(EOI), .SEOI(SEOI), .EOI_LEVEL(EOI_LEVEL),
    .INT(INT), .IRR(IRR), .ISR(ISR), .VECTOR(VECTOR), .VEC_VALID(VEC_VALID));

  always #5 CLK = ~CLK;

  typedef struct {
    bit rst; logic [7:0] ir, im; bit inta_n, eoi;
    bit e_int; logic [7:0] e_irr, e_isr; bit e_vv; logic [7:0] e_vec;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // priority order: level (low+1)%N first, descending circularly
  function automatic int top(input logic [7:0] v, input int low);
    for (int r = 0; r < N; r++) if (v[(low + 1 + r) % N]) return (low + 1 + r) % N;
    return -1;
  endfunction

  function automatic int prio(input int lvl, input int low);
    return (lvl - low - 1 + N) % N;
  endfunction

  task automatic model_update();
    int lowe, win, it, nstate;
    logic pulse, ack;
    logic [7:0] n_irr, n_isr;
    if (RST) begin
      m_irr = 0; m_isr = 0; m_int = 0; m_vec = 0; m_vv = 0; m_state = 0;
      m_low = N - 1; m_k = N - 1; m_ir_prev = 0; m_inta_prev = 1;
      return;
    end
    lowe   = ROT_MODE[1] ? m_low : N - 1;
    win    = top(m_irr & ~IM, lowe);
    it     = top(m_isr, lowe);
    pulse  = m_inta_prev && !INTA_N;
    nstate = pulse ? 1 - m_state : m_state;
    ack    = pulse && m_state == 0 && win >= 0;
    n_isr  = m_isr;
    if (EOI && it >= 0) n_isr[it] = 0;
    if (SEOI) n_isr[EOI_LEVEL] = 0;
    n_irr = LTIM ? IR : m_irr;
    if (ack) begin n_irr[win] = 0; n_isr[win] = 1; end
    if (!LTIM) n_irr = n_irr | (IR & ~m_ir_prev);
    m_int = nstate == 0 && win >= 0 && (it < 0 || prio(win, lowe) < prio(it, lowe));
    m_vv  = pulse && m_state == 1;
    if (m_vv) m_vec = 8'((8'h20 & ~(N - 1)) | m_k);
    if (pulse && m_state == 0) m_k = win >= 0 ? win : N - 1;
    if (ROT_MODE == 2'b11) m_low = int'(ROT_LEVEL);
    else if (ROT_MODE == 2'b10) begin if (ack) m_low = win; end
    else m_low = N - 1;
    m_irr = n_irr; m_isr = n_isr; m_state = nstate;
    m_inta_prev = INTA_N; m_ir_prev = IR;
  endtask

  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
    if (chk_model) begin
      chk("m_int", INT, m_int);
      chk("m_irr", IRR, m_irr);
      chk("m_isr", ISR, m_isr);
      chk("m_vv", VEC_VALID, m_vv);
      chk("m_vec", VECTOR, m_vec);
    end
  endtask

  task automatic do_reset();
    RST = 1; IR = 0; IM = 0; LTIM = 0; ROT_MODE = 0; ROT_LEVEL = 0;
    INTA_N = 1; EOI = 0; SEOI = 0; EOI_LEVEL = 0;
    step();
    RST = 0;
  endtask

  task automatic ack(output logic [7:0] v, output logic vv);
    INTA_N = 0; step(); INTA_N = 1; step();
    INTA_N = 0; step(); v = VECTOR; vv = VEC_VALID;
    INTA_N = 1; step();
  endtask

  initial begin
    logic [7:0] v;
    logic vv;
    tbl[0]  = '{0, 8'h14, 8'h00, 1, 0, 0, 8'h14, 8'h00, 0, 8'h00};
    tbl[1]  = '{0, 8'h14, 8'h00, 1, 0, 1, 8'h14, 8'h00, 0, 8'h00};
    tbl[2]  = '{0, 8'h14, 8'h00, 0, 0, 0, 8'h10, 8'h04, 0, 8'h00};
    tbl[3]  = '{0, 8'h14, 8'h00, 1, 0, 0, 8'h10, 8'h04, 0, 8'h00};
    tbl[4]  = '{0, 8'h14, 8'h00, 0, 0, 0, 8'h10, 8'h04, 1, 8'h22};
    tbl[5]  = '{0, 8'h14, 8'h00, 1, 0, 0, 8'h10, 8'h04, 0, 8'h22};
    tbl[6]  = '{0, 8'h14, 8'h00, 1, 1, 0, 8'h10, 8'h00, 0, 8'h22};
    tbl[7]  = '{0, 8'h14, 8'h00, 1, 0, 1, 8'h10, 8'h00, 0, 8'h22};
    tbl[8]  = '{1, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00};
    tbl[9]  = '{0, 8'h14, 8'h04, 1, 0, 0, 8'h14, 8'h00, 0, 8'h00};
    tbl[10] = '{0, 8'h14, 8'h04, 1, 0, 1, 8'h14, 8'h00, 0, 8'h00};
    tbl[11] = '{0, 8'h14, 8'h04, 0, 0, 0, 8'h04, 8'h10, 0, 8'h00};
    tbl[12] = '{0, 8'h14, 8'h04, 1, 0, 0, 8'h04, 8'h10, 0, 8'h00};
    tbl[13] = '{0, 8'h14, 8'h04, 0, 0, 0, 8'h04, 8'h10, 1, 8'h24};
    tbl[14] = '{0, 8'h14, 8'h04, 1, 0, 0, 8'h04, 8'h10, 0, 8'h24};
    do_reset();
    chk("rst_int", INT, 0); chk("rst_irr", IRR, 0); chk("rst_isr", ISR, 0);
    chk("rst_vv", VEC_VALID, 0); chk("rst_vec", VECTOR, 0);
    for (int i = 0; i < 15; i++) begin
      RST = tbl[i].rst; IR = tbl[i].ir; IM = tbl[i].im; INTA_N = tbl[i].inta_n; EOI = tbl[i].eoi;
      step();
      chk($sformatf("t%0d_int", i), INT, tbl[i].e_int);
      chk($sformatf("t%0d_irr", i), IRR, tbl[i].e_irr);
      chk($sformatf("t%0d_isr", i), ISR, tbl[i].e_isr);
      chk($sformatf("t%0d_vv", i), VEC_VALID, tbl[i].e_vv);
      chk($sformatf("t%0d_vec", i), VECTOR, tbl[i].e_vec);
    end
    RST = 0; EOI = 0;
    do_reset();
    ROT_MODE = 2'b10; IR = 8'h03; step(); step();
    ack(v, vv);
    chk("rot_vec0", v, 8'h20); chk("rot_vv0", vv, 1); chk("rot_isr0", ISR, 8'h01);
    EOI = 1; step(); EOI = 0;
    chk("rot_eoi0", ISR, 8'h00);
    ack(v, vv);
    chk("rot_vec1", v, 8'h21); chk("rot_isr1", ISR, 8'h02);
    EOI = 1; step(); EOI = 0;
    IR = 8'h00; step(); IR = 8'h21; step();
    ack(v, vv);
    chk("rot_vec5", v, 8'h25); chk("rot_isr5", ISR, 8'h20);
    do_reset();
    ROT_MODE = 2'b11; ROT_LEVEL = 3; IR = 8'h24; step(); step();
    chk("spec_int", INT, 1);
    ack(v, vv);
    chk("spec_vec", v, 8'h25); chk("spec_isr", ISR, 8'h20); chk("spec_irr", IRR, 8'h04);
    do_reset();
    LTIM = 1; IR = 8'h08; step();
    chk("lvl_irr", IRR, 8'h08);
    IR = 8'h00; step();
    chk("lvl_irr0", IRR, 8'h00);
    ack(v, vv);
    chk("spur_vec", v, 8'h27); chk("spur_vv", vv, 1); chk("spur_isr", ISR, 8'h00);
    do_reset();
    IR = 8'h02; step(); step();
    INTA_N = 0; step();
    chk("abort_isr1", ISR, 8'h02);
    INTA_N = 1; RST = 1; step(); RST = 0;
    chk("abort_isr", ISR, 0); chk("abort_irr", IRR, 0); chk("abort_int", INT, 0);
    chk("abort_vv", VEC_VALID, 0); chk("abort_vec", VECTOR, 0);
    step();
    chk("abort_vv2", VEC_VALID, 0); chk("abort_irr2", IRR, 8'h02);
    ack(v, vv);
    chk("fresh_vec", v, 8'h21); chk("fresh_vv", vv, 1);
    do_reset();
    chk_model = 1;
    for (int c = 0; c < 3000; c++) begin
      IR = IR ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 19) == 0) IM = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 49) == 0) LTIM = 1'($urandom);
      if ($urandom_range(0, 49) == 0) ROT_MODE = 2'($urandom);
      ROT_LEVEL = 3'($urandom);
      if ($urandom_range(0, 2) == 0) INTA_N = ~INTA_N;
      EOI = $urandom_range(0, 7) == 0;
      SEOI = $urandom_range(0, 9) == 0;
      EOI_LEVEL = 3'($urandom);
      RST = $urandom_range(0, 299) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
